// File: rtl/buzzer_note_scheduler_pkg.sv
// Shared definitions for the buzzer note scheduler: FSM states, the 32-bit
// note event layout and clock-derived timing defaults.
package buzzer_note_scheduler_pkg;

    localparam int CLK_FRE       = 50_000_000;
    localparam int TICK_DIV_DFLT = CLK_FRE / 1000;

    // Field positions inside a packed note event word
    localparam int NOTE_MSB = 31;
    localparam int NOTE_LSB = 24;
    localparam int VELO_MSB = 23;
    localparam int VELO_LSB = 16;
    localparam int TIME_MSB = 15;
    localparam int TIME_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } buzz_state_e;

    typedef struct packed {
        logic [7:0]  note;
        logic [7:0]  velo;
        logic [15:0] dur;
    } note_evt_t;

    function automatic logic note_is_sound(input logic [7:0] note);
        return (note != 8'd0);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick divider: one-cycle tick every TICK_DIV clocks, with a
// synchronous restart so a new interval can be aligned to an event.
module ms_tick_gen
    import buzzer_note_scheduler_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DFLT
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(TICK_DIV - 1));

    // Divider count, cleared on restart or on reaching the terminal value
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_restart || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/buzzer_note_scheduler.sv
// Fixed-priority scheduler feeding timed notes from NUM_REQ sources to one
// tone generator. Define BUZZ_PREEMPT_EN to let a lower index cut a note short.
module buzzer_note_scheduler
    import buzzer_note_scheduler_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int TICK_DIV = TICK_DIV_DFLT,
    parameter int GAP_MS   = 0,
    parameter int OWNER_W  = 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_en,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  logic [8*NUM_REQ-1:0]  i_req_note,
    input  logic [8*NUM_REQ-1:0]  i_req_velo,
    input  logic [16*NUM_REQ-1:0] i_req_time,
    output logic [7:0]            o_note_out,
    output logic [7:0]            o_velo_out,
    output logic                  o_note_active,
    output logic                  o_busy,
    output logic [OWNER_W-1:0]    o_owner,
    output logic [NUM_REQ-1:0]    o_done,
    output logic [NUM_REQ-1:0]    o_aborted
);

    buzz_state_e         r_state;
    buzz_state_e         w_next_state;
    logic [OWNER_W-1:0]  r_owner;
    logic [OWNER_W-1:0]  w_grant_idx;
    logic                w_any_valid;
    logic [31:0]         w_sel_bits;
    note_evt_t           w_sel_evt;
    logic                w_accept;
    logic                w_tick;
    logic                w_restart;
    logic                w_ms_last;
    logic                w_play_done;
    logic                w_abort_play;
    logic                w_zero_done;
    logic                w_preempt;
    logic [15:0]         r_ms;
    logic [7:0]          r_note_out;
    logic [7:0]          r_velo_out;
    logic                r_note_active;
    logic [NUM_REQ-1:0]  r_done;
    logic [NUM_REQ-1:0]  r_aborted;

    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [OWNER_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = (idx == OWNER_W'(i));
        end
        return v;
    endfunction

    // Priority encoder: scanning downwards leaves the lowest valid index selected
    always_comb begin
        w_any_valid = 1'b0;
        w_grant_idx = '0;
        w_sel_bits  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_any_valid = w_any_valid | i_req_valid[i];
            w_grant_idx = i_req_valid[i] ? OWNER_W'(i) : w_grant_idx;
            w_sel_bits  = i_req_valid[i] ?
                          {i_req_note[8*i +: 8], i_req_velo[8*i +: 8], i_req_time[16*i +: 16]} :
                          w_sel_bits;
        end
    end

    assign w_sel_evt   = note_evt_t'(w_sel_bits);
    assign w_accept    = (r_state == ST_IDLE) && i_en && w_any_valid;
    assign o_req_ready = w_accept ? idx_onehot(w_grant_idx) : '0;

`ifdef BUZZ_PREEMPT_EN
    logic w_hi_valid;

    // Any pending request that outranks the requester currently being served
    always_comb begin
        w_hi_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_hi_valid = w_hi_valid | (i_req_valid[i] && (OWNER_W'(i) < r_owner));
        end
    end

    assign w_preempt = i_en && (r_state != ST_IDLE) && w_hi_valid;
`else
    assign w_preempt = 1'b0;
`endif

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_ms_tick (
        .clk       (clk),
        .rstn      (rstn),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    assign w_ms_last    = w_tick && (r_ms == 16'd1);
    assign w_play_done  = (r_state == ST_PLAY) && i_en && !w_preempt && w_ms_last;
    assign w_abort_play = (r_state == ST_PLAY) && (!i_en || w_preempt);
    assign w_zero_done  = w_accept && (w_sel_evt.dur == 16'd0);
    assign w_restart    = w_accept || w_play_done;

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (w_sel_evt.dur != 16'd0)) begin
                    w_next_state = ST_PLAY;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (w_abort_play) begin
                    w_next_state = ST_IDLE;
                end else if (w_play_done) begin
                    w_next_state = (GAP_MS > 0) ? ST_GAP : ST_IDLE;
                end else begin
                    w_next_state = ST_PLAY;
                end
            end
            ST_GAP: begin
                if (!i_en || w_preempt || w_ms_last) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_GAP;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, owner and remaining-millisecond registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ms    <= 16'd0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_owner <= w_grant_idx;
                r_ms    <= w_sel_evt.dur;
            end else if (w_play_done) begin
                r_ms    <= 16'(GAP_MS);
            end else if (w_tick && (r_state != ST_IDLE)) begin
                r_ms    <= r_ms - 16'd1;
            end
        end
    end

    // Tone outputs are loaded on accept and held only while the next state is PLAY
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_note_out    <= 8'd0;
            r_velo_out    <= 8'd0;
            r_note_active <= 1'b0;
            r_done        <= '0;
            r_aborted     <= '0;
        end else begin
            if (w_accept && (w_sel_evt.dur != 16'd0)) begin
                r_note_out    <= w_sel_evt.note;
                r_velo_out    <= w_sel_evt.velo;
                r_note_active <= note_is_sound(w_sel_evt.note);
            end else if (w_next_state != ST_PLAY) begin
                r_note_out    <= 8'd0;
                r_velo_out    <= 8'd0;
                r_note_active <= 1'b0;
            end
            r_done    <= (w_play_done ? idx_onehot(r_owner) : '0) |
                         (w_zero_done ? idx_onehot(w_grant_idx) : '0);
            r_aborted <= w_abort_play ? idx_onehot(r_owner) : '0;
        end
    end

    assign o_note_out    = r_note_out;
    assign o_velo_out    = r_velo_out;
    assign o_note_active = r_note_active;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_owner       = r_owner;
    assign o_done        = r_done;
    assign o_aborted     = r_aborted;

endmodule
